// File: rtl/reg_write_arbiter.sv
`default_nettype none
// =============================================================================
// reg_write_arbiter: round-robin owner of the register-bank write port,
// bounded to MAX_HOLD write cycles per tenure.         Revision 1.0
// =============================================================================
module reg_write_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_HOLD   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DATA_WIDTH-1:0] wr_data_in,
   output logic [N_REQ-1:0]            grant,
   output logic                        bank_en,
   output logic [DATA_WIDTH-1:0]       bank_data,
   output logic                        busy
);
   localparam int PTR_W  = $clog2(N_REQ);
   localparam int SCAN_W = PTR_W + 1;
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [PTR_W-1:0]  LAST_RST  = PTR_W'(N_REQ - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [SCAN_W-1:0] SCAN_N    = SCAN_W'(N_REQ);
   localparam logic [N_REQ-1:0]  GRANT_ONE = N_REQ'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [N_REQ-1:0]   grant_nxt;
   logic [PTR_W-1:0]   owner, owner_nxt;
   logic [PTR_W-1:0]   last_ptr, last_ptr_nxt;
   logic [PTR_W-1:0]   sel;
   logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
   logic [SCAN_W-1:0]  scan_idx;
   logic               owner_req;

   // Scan farthest-to-nearest so the requester closest after last_ptr wins.
   always_comb begin
      sel      = '0;
      scan_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         scan_idx = {1'b0, last_ptr} + SCAN_W'(k);
         if (scan_idx >= SCAN_N) begin
            scan_idx = scan_idx - SCAN_N;
         end
         if (req[scan_idx[PTR_W-1:0]]) begin
            sel = scan_idx[PTR_W-1:0];
         end
      end
   end

   assign owner_req = req[owner];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         grant    <= '0;
         owner    <= '0;
         hold_cnt <= '0;
         last_ptr <= LAST_RST;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         owner    <= owner_nxt;
         hold_cnt <= hold_cnt_nxt;
         last_ptr <= last_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      owner_nxt    = owner;
      hold_cnt_nxt = hold_cnt;
      last_ptr_nxt = last_ptr;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt    = GRANT;
               grant_nxt    = GRANT_ONE << sel;
               owner_nxt    = sel;
               hold_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (owner_req) begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
            // A tenure ends when the owner lets go or has used its last write slot.
            if (!owner_req || (hold_cnt == HOLD_LAST)) begin
               state_nxt    = RELEASE;
               grant_nxt    = '0;
               last_ptr_nxt = owner;
            end
         end
         RELEASE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bank_en   = (state == GRANT) && owner_req;
   assign bank_data = bank_en ? wr_data_in[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// =============================================================================
// tb_reg_write_arbiter: vector table, corner sequences and a randomized run
// against a tenure-level reference model.              Revision 1.0
// =============================================================================
module tb_reg_write_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MH = 4;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*DW-1:0] wr_data_in;
   logic [N-1:0]    grant;
   logic            bank_en;
   logic [DW-1:0]   bank_data;
   logic            busy;

   int tests  = 0;
   int failed = 0;

   // Model: who owns the port, how many writes it has made, who was served last,
   // and whether the one-cycle turnaround is pending.
   int m_owner;
   int m_writes;
   int m_last;
   bit m_gap;

   reg_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .wr_data_in (wr_data_in),
      .grant      (grant),
      .bank_en    (bank_en),
      .bank_data  (bank_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic [N-1:0]  rq;
      logic [31:0]   data;
      logic [N-1:0]  g;
      logic          en;
      logic [DW-1:0] bd;
      logic          bsy;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_owner  = -1;
      m_writes = 0;
      m_last   = N - 1;
      m_gap    = 1'b0;
   endfunction

   function automatic void model_edge();
      if (!reset) begin
         model_reset();
      end else if (m_owner >= 0) begin
         if (req[m_owner]) m_writes++;
         if (!req[m_owner] || m_writes == MH) begin
            m_last  = m_owner;
            m_owner = -1;
            m_gap   = 1'b1;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else if (req != '0) begin
         for (int k = 1; k <= N; k++) begin
            if (req[(m_last + k) % N]) begin
               m_owner = (m_last + k) % N;
               break;
            end
         end
         m_writes = 0;
      end
   endfunction

   task automatic drive(input logic r_n, input logic [N-1:0] rq, input logic [N*DW-1:0] d);
      reset      = r_n;
      req        = rq;
      wr_data_in = d;
      #4;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0]  eg;
      logic          ee;
      logic [DW-1:0] ed;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      ee = (m_owner >= 0) && req[m_owner];
      ed = ee ? wr_data_in[m_owner*DW +: DW] : '0;
      chk({tag, "_grant"}, 32'(grant), 32'(eg));
      chk({tag, "_en"},    32'(bank_en), 32'(ee));
      chk({tag, "_data"},  32'(bank_data), 32'(ed));
      chk({tag, "_busy"},  32'(busy), 32'((m_owner >= 0) || m_gap));
      chk({tag, "_onehot"}, 32'($onehot0(grant)), 32'd1);
   endtask

   task automatic run(input logic [N-1:0] rq, input logic [N*DW-1:0] d, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, rq, d);
         check_model(tag);
         tick();
      end
   endtask

   initial begin
      int order[$];
      int exp_ord[5];
      int wr_cnt;
      logic [N-1:0] prev_g;
      logic [31:0] d;
      bit exp_en;

      model_reset();
      exp_ord = '{0, 1, 2, 3, 0};

      // Vector table: reset, a short tenure for 0, a 2-write tenure for 2.
      tbl[0]  = '{1'b0, 4'hF, 32'h0,         4'h0, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b1, 4'hF, 32'h0,         4'h0, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b1, 4'hF, 32'h44332211,  4'h1, 1'b1, 8'h11, 1'b1};
      tbl[3]  = '{1'b1, 4'h0, 32'h44332211,  4'h1, 1'b0, 8'h00, 1'b1};
      tbl[4]  = '{1'b1, 4'h0, 32'h0,         4'h0, 1'b0, 8'h00, 1'b1};
      tbl[5]  = '{1'b1, 4'h0, 32'h00A50000,  4'h0, 1'b0, 8'h00, 1'b0};
      tbl[6]  = '{1'b1, 4'h4, 32'h00A50000,  4'h0, 1'b0, 8'h00, 1'b0};
      tbl[7]  = '{1'b1, 4'h4, 32'h00A50000,  4'h4, 1'b1, 8'hA5, 1'b1};
      tbl[8]  = '{1'b1, 4'h4, 32'h00A50000,  4'h4, 1'b1, 8'hA5, 1'b1};
      tbl[9]  = '{1'b1, 4'h0, 32'h00A50000,  4'h4, 1'b0, 8'h00, 1'b1};
      tbl[10] = '{1'b1, 4'h0, 32'h00A50000,  4'h0, 1'b0, 8'h00, 1'b1};
      tbl[11] = '{1'b1, 4'h0, 32'h00A50000,  4'h0, 1'b0, 8'h00, 1'b0};

      drive(1'b0, 4'hF, '0);
      tick();
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].rst, tbl[i].rq, tbl[i].data);
         chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
         chk($sformatf("tbl%0d_en", i),    32'(bank_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_data", i),  32'(bank_data), 32'(tbl[i].bd));
         chk($sformatf("tbl%0d_busy", i),  32'(busy), 32'(tbl[i].bsy));
         tick();
      end

      // Hold limit: lone requester 1 gets 4 writes, 2 dead cycles, 4 writes.
      drive(1'b0, '0, '0);
      tick();
      d = 32'h00_00_3C_00;
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, 4'b0010, d);
         exp_en = (i >= 1 && i <= 4) || (i >= 7 && i <= 10);
         chk($sformatf("hold%0d_en", i), 32'(bank_en), 32'(exp_en));
         chk($sformatf("hold%0d_grant", i), 32'(grant), exp_en ? 32'h2 : 32'h0);
         check_model("hold");
         tick();
      end

      // Round-robin fairness with all four requesting.
      drive(1'b0, '0, '0);
      tick();
      prev_g = '0;
      wr_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         drive(1'b1, 4'hF, 32'hD4C3B2A1);
         check_model("rr");
         if (grant != '0 && prev_g == '0) order.push_back($clog2(grant));
         if (bank_en) wr_cnt++;
         if (grant == '0 && prev_g != '0) begin
            chk("rr_tenure_writes", 32'(wr_cnt), 32'(MH));
            wr_cnt = 0;
         end
         prev_g = grant;
         tick();
      end
      chk("rr_tenures", 32'(order.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < order.size()) chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_ord[k]));
      end

      // Priority after service: 3 served, then 1001 -> 0, then 1001 -> 3.
      drive(1'b0, '0, '0);
      tick();
      run(4'b1000, 32'h11223344, 1, "prio");
      drive(1'b1, 4'b1000, 32'h11223344);
      chk("prio_g3", 32'(grant), 32'h8);
      tick();
      run(4'b0000, 32'h11223344, 1, "prio");
      run(4'b1001, 32'h11223344, 2, "prio");
      drive(1'b1, 4'b1001, 32'h11223344);
      chk("prio_after3", 32'(grant), 32'h1);
      tick();
      run(4'b1001, 32'h11223344, 5, "prio");
      drive(1'b1, 4'b1001, 32'h11223344);
      chk("prio_after0", 32'(grant), 32'h8);
      tick();

      // Reset on the 2nd write cycle of requester 1.
      drive(1'b0, '0, '0);
      tick();
      run(4'b0010, 32'h0000_5A00, 2, "mid");
      drive(1'b0, 4'b0010, 32'h0000_5A00);
      chk("mid_en_before", 32'(bank_en), 32'd1);
      tick();
      drive(1'b1, 4'b0010, 32'h0000_5A00);
      chk("mid_en_after", 32'(bank_en), 32'd0);
      chk("mid_grant_after", 32'(grant), 32'd0);
      chk("mid_busy_after", 32'(busy), 32'd0);
      tick();
      drive(1'b1, 4'b0010, 32'h0000_5A00);
      chk("mid_regrant", 32'(grant), 32'h2);
      tick();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] rq;
         logic         rn;
         rq = N'($urandom);
         if ($urandom_range(3) == 0) rq = '0;
         rn = ($urandom_range(49) != 0);
         drive(rn, rq, $urandom);
         check_model("rand");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
